// File: rtl/weight_sched_pkg.sv
// Shared types and sizing helpers for the weight load scheduler.
package weight_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } wls_state_t;

   localparam int unsigned MIN_CNT_W = 1;

   function automatic int burst_len(input int kernel_size);
      return kernel_size * kernel_size + 2;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : MIN_CNT_W;
   endfunction

endpackage

// File: rtl/glb_rd_mux.sv
// NUM_PE:1 GLB read request/address mux with base relocation.
module glb_rd_mux
   import weight_sched_pkg::*;
#(
   parameter int NUM_PE            = 3,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int SEL_W             = 2
) (
   input  logic [SEL_W-1:0]                    sel,
   input  logic                                en,
   input  logic [ADDR_BITWIDTH_GLB-1:0]        base,
   input  logic [NUM_PE*ADDR_BITWIDTH_GLB-1:0] r_addr_pe,
   input  logic [NUM_PE-1:0]                   read_req_pe,
   output logic [ADDR_BITWIDTH_GLB-1:0]        r_addr,
   output logic                                read_req
);

   logic [ADDR_BITWIDTH_GLB-1:0] rel;
   logic                         req_sel;

   always_comb begin
      rel     = '0;
      req_sel = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (sel == SEL_W'(i)) begin
            rel     = r_addr_pe[i*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
            req_sel = read_req_pe[i];
         end
      end
   end

   // Sum wraps modulo the GLB address space.
   assign r_addr   = en ? base + rel : base;
   assign read_req = en & req_sel;

endmodule

// File: rtl/weight_load_sched.sv
// Weight load sequencer: one router at a time owns the GLB weight port.
// Optional perf counters: define WEIGHT_LOAD_SCHED_PERF_EN.
module weight_load_sched
   import weight_sched_pkg::*;
#(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int NUM_PE            = 3,
   parameter int NUM_FILT          = 4,
   parameter int kernel_size       = 3,
   parameter int W_BASE_ADDR       = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic [NUM_PE-1:0]                   load_spad_ctrl,
   output logic [cnt_w(NUM_PE)-1:0]            pe_sel,
   output logic [cnt_w(NUM_FILT)-1:0]          filt_idx,
   input  logic [NUM_PE*ADDR_BITWIDTH_GLB-1:0] r_addr_pe,
   input  logic [NUM_PE-1:0]                   read_req_pe,
   output logic [ADDR_BITWIDTH_GLB-1:0]        r_addr_glb_wght,
   output logic                                read_req_glb_wght
`ifdef WEIGHT_LOAD_SCHED_PERF_EN
   ,
   output logic [31:0]                         perf_cycles,
   output logic [31:0]                         perf_stall
`endif
);

   localparam int PE_W = cnt_w(NUM_PE);
   localparam int FI_W = cnt_w(NUM_FILT);
   localparam int BL   = burst_len(kernel_size);
   localparam int WC_W = cnt_w(BL);
   localparam int K2   = kernel_size * kernel_size;

   localparam logic [PE_W-1:0]              PE_LAST = PE_W'(NUM_PE - 1);
   localparam logic [FI_W-1:0]              FI_LAST = FI_W'(NUM_FILT - 1);
   localparam logic [WC_W-1:0]              WC_LAST = WC_W'(BL - 1);
   localparam logic [ADDR_BITWIDTH_GLB-1:0] K2_A    = ADDR_BITWIDTH_GLB'(K2);
   localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE0   = ADDR_BITWIDTH_GLB'(W_BASE_ADDR);

   typedef logic [DATA_BITWIDTH-1:0] glb_word_t;

   wls_state_t                   state;
   logic [WC_W-1:0]              wait_cnt;
   logic [ADDR_BITWIDTH_GLB-1:0] base;

   function automatic logic [NUM_PE-1:0] pe_bit(input logic [PE_W-1:0] i);
      return NUM_PE'(1) << i;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         load_spad_ctrl <= '0;
         pe_sel         <= '0;
         filt_idx       <= '0;
         wait_cnt       <= '0;
         base           <= BASE0;
      end else begin
         load_spad_ctrl <= '0;
         done           <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state          <= ISSUE;
                  busy           <= 1'b1;
                  pe_sel         <= '0;
                  filt_idx       <= '0;
                  base           <= BASE0;
                  load_spad_ctrl <= pe_bit('0);
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + WC_W'(1);
               if (wait_cnt == WC_LAST) begin
                  base <= base + K2_A;
                  if (pe_sel != PE_LAST) begin
                     pe_sel         <= pe_sel + PE_W'(1);
                     load_spad_ctrl <= pe_bit(pe_sel + PE_W'(1));
                     state          <= ISSUE;
                  end else begin
                     pe_sel <= '0;
                     if (filt_idx != FI_LAST) begin
                        filt_idx       <= filt_idx + FI_W'(1);
                        load_spad_ctrl <= pe_bit('0);
                        state          <= ISSUE;
                     end else begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   glb_rd_mux #(
      .NUM_PE            (NUM_PE),
      .ADDR_BITWIDTH_GLB (ADDR_BITWIDTH_GLB),
      .SEL_W             (PE_W)
   ) u_mux (
      .sel         (pe_sel),
      .en          (state != IDLE),
      .base        (base),
      .r_addr_pe   (r_addr_pe),
      .read_req_pe (read_req_pe),
      .r_addr      (r_addr_glb_wght),
      .read_req    (read_req_glb_wght)
   );

`ifdef WEIGHT_LOAD_SCHED_PERF_EN
   logic [NUM_PE-1:0] others;
   assign others = read_req_pe & ~pe_bit(pe_sel);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
         end
      end else begin
         perf_cycles <= perf_cycles + 32'd1;
         if (state == WAIT && |others)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed/random bench for weight_load_sched against a load-schedule model.
module tb_weight_load_sched;

   localparam int A        = 10;
   localparam int NP       = 3;
   localparam int NF       = 4;
   localparam int K2       = 9;
   localparam int LOAD_CYC = K2 + 3;
   localparam int SEQ      = NP * NF * LOAD_CYC;
   localparam int WB       = 1020;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [NP*A-1:0] r_addr_pe = '0;
   logic [NP-1:0] read_req_pe = '0;

   logic          busy, done, req;
   logic [NP-1:0] lsc;
   logic [1:0]    pe_sel, filt_idx;
   logic [A-1:0]  addr;

   logic          busy_w, done_w, req_w;
   logic [NP-1:0] lsc_w;
   logic [1:0]    pe_w, fi_w;
   logic [A-1:0]  addr_w;

   int checks = 0;
   int failures = 0;
   int m_fi = 0;
   int m_ld = 0;
   int n_done = 0;
   int n_load = 0;

   always #5 clk = ~clk;

   weight_load_sched dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .load_spad_ctrl    (lsc),
      .pe_sel            (pe_sel),
      .filt_idx          (filt_idx),
      .r_addr_pe         (r_addr_pe),
      .read_req_pe       (read_req_pe),
      .r_addr_glb_wght   (addr),
      .read_req_glb_wght (req)
   );

   weight_load_sched #(.W_BASE_ADDR(WB)) dut_w (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .busy              (busy_w),
      .done              (done_w),
      .load_spad_ctrl    (lsc_w),
      .pe_sel            (pe_w),
      .filt_idx          (fi_w),
      .r_addr_pe         (r_addr_pe),
      .read_req_pe       (read_req_pe),
      .r_addr_glb_wght   (addr_w),
      .read_req_glb_wght (req_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      for (int i = 0; i < NP; i++)
         r_addr_pe[i*A +: A] = A'($urandom_range(0, 1023));
      read_req_pe = NP'($urandom_range(0, 7));
   endtask

   // k counts cycles since the first ISSUE; act=0 means idle.
   task automatic check_cycle(input string tag, input bit act, input int k);
      int ld, pe, fi, sl, b, bw;
      bit dn, bz, rq;
      logic [NP-1:0] ld_e;
      #1;
      if (act && k < SEQ) begin
         ld   = k / LOAD_CYC;
         pe   = ld % NP;
         fi   = ld / NP;
         dn   = 1'b0;
         ld_e = (k % LOAD_CYC == 0) ? (NP'(1) << pe) : '0;
      end else if (act) begin
         ld   = NP * NF;
         pe   = 0;
         fi   = NF - 1;
         dn   = 1'b1;
         ld_e = '0;
      end else begin
         ld   = m_ld;
         pe   = 0;
         fi   = m_fi;
         dn   = 1'b0;
         ld_e = '0;
      end
      bz = act;
      b  = (K2 * ld) % 1024;
      bw = (WB + K2 * ld) % 1024;
      sl = int'(r_addr_pe[pe*A +: A]);
      rq = act && read_req_pe[pe];
      if (lsc != '0) n_load++;
      if (done) n_done++;
      chk({tag, ".busy"}, 32'(busy), 32'(bz));
      chk({tag, ".done"}, 32'(done), 32'(dn));
      chk({tag, ".load"}, 32'(lsc), 32'(ld_e));
      chk({tag, ".pe_sel"}, 32'(pe_sel), 32'(pe));
      chk({tag, ".filt"}, 32'(filt_idx), 32'(fi));
      chk({tag, ".req"}, 32'(req), 32'(rq));
      chk({tag, ".addr"}, 32'(addr), act ? 32'((b + sl) % 1024) : 32'(b));
      chk({tag, ".addr_w"}, 32'(addr_w), act ? 32'((bw + sl) % 1024) : 32'(bw));
      chk({tag, ".req_w"}, 32'(req_w), 32'(rq));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      repeat (2) begin
         tick(); rand_in(); check_cycle("reset", 0, 0);
      end
      reset = 1'b0;
      start = 1'b0;
      tick(); rand_in(); check_cycle("idle0", 0, 0);

      // Sequence 1 with directed grant/wrap probes.
      start = 1'b1;
      for (int k = 0; k <= SEQ; k++) begin
         tick(); rand_in();
         if (k == 0) r_addr_pe[A-1:0] = A'(7);
         if (k == 2*LOAD_CYC + 5) read_req_pe = 3'b001;
         if (k == 7*LOAD_CYC + 3) begin
            read_req_pe = 3'b010;
            r_addr_pe[2*A-1:A] = A'(5);
         end
         check_cycle("seq1", 1, k);
         if (k == 0) begin
            chk("wrap_addr", 32'(addr_w), 32'd3);
            start = 1'b0;
         end
         if (k == 2*LOAD_CYC + 5) chk("nongrant_req", 32'(req), 32'd0);
         if (k == 7*LOAD_CYC + 3) begin
            chk("grant_addr", 32'(addr), 32'd68);
            chk("grant_req", 32'(req), 32'd1);
         end
      end
      m_fi = NF - 1;
      m_ld = NP * NF;
      tick(); rand_in(); check_cycle("idle1", 0, 0);
      chk("done_count1", 32'(n_done), 32'd1);
      chk("load_count1", 32'(n_load), 32'd12);

      // Sequence 2: start held high, restarts only from IDLE.
      start = 1'b1;
      for (int k = 0; k <= SEQ; k++) begin
         tick(); rand_in(); check_cycle("seq2", 1, k);
      end
      tick(); rand_in(); check_cycle("idle2", 0, 0);
      for (int k = 0; k <= 5*LOAD_CYC + 4; k++) begin
         tick(); rand_in(); check_cycle("seq2b", 1, k);
         if (k == 0) start = 1'b0;
      end

      // Abort mid-WAIT of load 5.
      reset = 1'b1;
      m_fi = 0;
      m_ld = 0;
      tick(); rand_in(); check_cycle("abort", 0, 0);
      reset = 1'b0;
      repeat (3) begin
         tick(); rand_in(); check_cycle("idle3", 0, 0);
      end
      chk("done_count2", 32'(n_done), 32'd2);

      // Sequence 3 replays from PE0/filter0.
      start = 1'b1;
      for (int k = 0; k <= SEQ; k++) begin
         tick(); rand_in(); check_cycle("seq3", 1, k);
         if (k == 0) start = 1'b0;
      end
      m_fi = NF - 1;
      m_ld = NP * NF;
      tick(); rand_in(); check_cycle("idle4", 0, 0);
      chk("done_count3", 32'(n_done), 32'd3);
      chk("load_count3", 32'(n_load), 32'd42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
